formal_bus_model: RTL

FORMAL_BUS_MODEL -- requirements
Module: formal_bus_model

---
 rtl/formal_bus_model.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/formal_bus_model.sv
// Formal-style bus slave model: randomized ack timing with a bounded stall,
// a single shadow word at a symbolic tracked address for read/write
// coherence, and a sticky flag for master protocol violations.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus__req        per-port request pending
//   bus__addr       per-port byte address (port i at slice i)
//   bus__wmask      per-port byte write mask, all-zero = read
//   bus__wdata      per-port write data
//   bus__ack        per-port transfer complete (combinational)
//   bus__rdata      per-port read data (combinational)
//   rnd_ack         free ack choice per port
//   rnd_data        free read data per port
//   track_addr      tracked address, sampled once after reset
//   protocol_err    sticky master protocol-violation flag
module formal_bus_model #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 4,
    parameter int unsigned TRACK_MEM  = 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_PORTS-1:0]                     bus__req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]          bus__addr,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]      bus__wmask,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]          bus__wdata,
    output logic [NUM_PORTS-1:0]                     bus__ack,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]          bus__rdata,
    input  logic [NUM_PORTS-1:0]                     rnd_ack,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]          rnd_data,
    input  logic [ADDR_WIDTH-1:0]                    track_addr,
    output logic                                     protocol_err
);

    localparam int unsigned LANES    = DATA_WIDTH / 8;
    localparam int unsigned OFF_BITS = (LANES > 1) ? $clog2(LANES) : 0;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFF_BITS;
    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);
    localparam bit TRACK = (TRACK_MEM != 0);

    logic [3:0]                      wait_cnt [NUM_PORTS];
    logic                            trk_latched;
    logic [ADDR_WIDTH-1:0]           trk_addr;
    logic [DATA_WIDTH-1:0]           shadow, shadow_nxt;
    logic [LANES-1:0]                valid, valid_nxt;
    logic [NUM_PORTS-1:0]            prev_stall;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] prev_addr;
    logic [NUM_PORTS*LANES-1:0]      prev_wmask;
    logic [NUM_PORTS*DATA_WIDTH-1:0] prev_wdata;
    logic [NUM_PORTS-1:0]            hit_word;
    logic                            viol;

    // Ack: free choice, forced once the stall bound is reached; never without req.
    always_comb begin
        bus__ack = '0;
        hit_word = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            hit_word[i] = trk_latched &&
                ((bus__addr[i*ADDR_WIDTH +: ADDR_WIDTH] & ALIGN_MASK) == trk_addr);
            bus__ack[i] = rst_n & bus__req[i] & (rnd_ack[i] | (wait_cnt[i] == MAX_CNT));
        end
    end

    // Read data per lane: valid shadow lane at the tracked word, else free data.
    // Uses the registered shadow, so a same-cycle write is not visible yet.
    always_comb begin
        bus__rdata = rnd_data;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int l = 0; l < LANES; l++) begin
                if (TRACK && hit_word[i] && valid[l]) begin
                    bus__rdata[i*DATA_WIDTH + l*8 +: 8] = shadow[l*8 +: 8];
                end
            end
        end
    end

    // Shadow update; ascending port order lets the highest port win per lane.
    always_comb begin
        shadow_nxt = shadow;
        valid_nxt  = valid;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (TRACK && bus__ack[i] && hit_word[i] &&
                (bus__wmask[i*LANES +: LANES] != '0)) begin
                for (int l = 0; l < LANES; l++) begin
                    if (bus__wmask[i*LANES + l]) begin
                        shadow_nxt[l*8 +: 8] = bus__wdata[i*DATA_WIDTH + l*8 +: 8];
                        valid_nxt[l]         = 1'b1;
                    end
                end
            end
        end
    end

    // A stalled request must be held unchanged until acked.
    always_comb begin
        viol = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (prev_stall[i] &&
                (!bus__req[i] ||
                 (bus__addr[i*ADDR_WIDTH +: ADDR_WIDTH] != prev_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) ||
                 (bus__wmask[i*LANES +: LANES] != prev_wmask[i*LANES +: LANES]) ||
                 (bus__wdata[i*DATA_WIDTH +: DATA_WIDTH] != prev_wdata[i*DATA_WIDTH +: DATA_WIDTH]))) begin
                viol = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wait_cnt[i] <= '0;
            end
            trk_latched  <= 1'b0;
            trk_addr     <= '0;
            shadow       <= '0;
            valid        <= '0;
            prev_stall   <= '0;
            prev_addr    <= '0;
            prev_wmask   <= '0;
            prev_wdata   <= '0;
            protocol_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wait_cnt[i] <= (bus__req[i] && !bus__ack[i]) ? wait_cnt[i] + 4'd1 : 4'd0;
            end
            if (!trk_latched) begin
                trk_latched <= 1'b1;
                trk_addr    <= track_addr & ALIGN_MASK;
            end
            shadow     <= shadow_nxt;
            valid      <= valid_nxt;
            prev_stall <= bus__req & ~bus__ack;
            prev_addr  <= bus__addr;
            prev_wmask <= bus__wmask;
            prev_wdata <= bus__wdata;
            if (viol) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule
